// File: rtl/mem_pkg.sv
// Shared encodings, FSM state type and lane helpers for the read-modify-write memory front-end.
package mem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_RSVD = 2'b11;

    typedef enum logic [2:0] {
        StIdle,
        StRd,
        StMerge,
        StWr,
        StDone
    } state_e;

    function automatic logic is_illegal(input logic [1:0] size, input logic [1:0] off);
        return (size == SZ_RSVD) ||
               ((size == SZ_HALF) && off[0]) ||
               ((size == SZ_WORD) && (off != 2'b00));
    endfunction

    // Replace the addressed lane(s) of old_word with the right-justified store data.
    function automatic logic [31:0] lane_merge(input logic [31:0] old_word,
                                               input logic [31:0] wdata,
                                               input logic [1:0]  size,
                                               input logic [1:0]  off);
        logic [31:0] res;
        res = old_word;
        if (size == SZ_BYTE) begin
            res[{off, 3'b000} +: 8] = wdata[7:0];
        end else if (size == SZ_HALF) begin
            res[{off[1], 4'b0000} +: 16] = wdata[15:0];
        end else begin
            res = wdata;
        end
        return res;
    endfunction

    function automatic logic [31:0] load_extract(input logic [31:0] word,
                                                 input logic [1:0]  size,
                                                 input logic [1:0]  off);
        logic [31:0] sh;
        logic [31:0] res;
        sh = word >> {off, 3'b000};
        if (size == SZ_BYTE) begin
            res = {24'h0, sh[7:0]};
        end else if (size == SZ_HALF) begin
            res = {16'h0, sh[15:0]};
        end else begin
            res = sh;
        end
        return res;
    endfunction

endpackage

// File: rtl/mem_rmw_arbiter_if.sv
// Requester-side bus: request fields from the master, completion pulse and load data back.
interface mem_rmw_arbiter_if #(
    parameter int unsigned WORD_ADDR_W = 16
) ();

    logic                   req;
    logic                   we;
    logic [1:0]             size;
    logic [WORD_ADDR_W+1:0] addr;
    logic [31:0]            wdata;
    logic                   ack;
    logic                   err;
    logic [31:0]            rdata;

    modport master (
        output req, we, size, addr, wdata,
        input  ack, err, rdata
    );

    modport slave (
        input  req, we, size, addr, wdata,
        output ack, err, rdata
    );

endinterface

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; last_q remembers the last winner so a tie goes to the other side.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic       en_i,
    input  logic [1:0] req_i,
    output logic       gnt_valid_o,
    output logic       gnt_id_o
);

    logic last_q, last_d;

    always_comb begin
        gnt_valid_o = en_i && (req_i != 2'b00);
        case (req_i)
            2'b01:   gnt_id_o = 1'b0;
            2'b10:   gnt_id_o = 1'b1;
            2'b11:   gnt_id_o = ~last_q;
            default: gnt_id_o = 1'b0;
        endcase
        last_d = gnt_valid_o ? gnt_id_o : last_q;
    end

    // Reset value marks B as last winner so A wins the first tie.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/mem_rmw_arbiter.sv
// Two-requester front-end to a word-only memory: arbitrates, checks alignment and
// turns byte/halfword stores into read-modify-write sequences.
module mem_rmw_arbiter
    import mem_pkg::*;
#(
    parameter int unsigned WORD_ADDR_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    mem_rmw_arbiter_if.slave       a_if,
    mem_rmw_arbiter_if.slave       b_if,
    output logic [WORD_ADDR_W-1:0] mem_addr,
    output logic [1:0]             mem_byte_sel,
    output logic                   mem_we,
    output logic                   mem_re,
    output logic [31:0]            mem_wdata,
    input  logic [31:0]            mem_rdata
);

    state_e                 state_q, state_d;
    logic                   id_q, id_d;
    logic                   we_q, we_d;
    logic [1:0]             size_q, size_d;
    logic [WORD_ADDR_W+1:0] addr_q, addr_d;
    logic [31:0]            wdata_q, wdata_d;
    logic                   mem_we_q, mem_we_d;
    logic                   mem_re_q, mem_re_d;
    logic [31:0]            mem_wdata_q, mem_wdata_d;
    logic                   a_ack_q, a_ack_d, b_ack_q, b_ack_d;
    logic                   a_err_q, a_err_d, b_err_q, b_err_d;
    logic [31:0]            a_rdata_q, a_rdata_d, b_rdata_q, b_rdata_d;

    logic                   gnt_valid, gnt_id;
    logic                   sel_we;
    logic [1:0]             sel_size;
    logic [WORD_ADDR_W+1:0] sel_addr;
    logic [31:0]            sel_wdata;
    logic                   fin, fin_id, fin_err;
    logic [31:0]            fin_rdata;

    rr_arb2 u_arb (
        .clk         (clk),
        .rst         (rst),
        .en_i        (state_q == StIdle),
        .req_i       ({b_if.req, a_if.req}),
        .gnt_valid_o (gnt_valid),
        .gnt_id_o    (gnt_id)
    );

    assign sel_we    = gnt_id ? b_if.we    : a_if.we;
    assign sel_size  = gnt_id ? b_if.size  : a_if.size;
    assign sel_addr  = gnt_id ? b_if.addr  : a_if.addr;
    assign sel_wdata = gnt_id ? b_if.wdata : a_if.wdata;

    always_comb begin
        state_d     = state_q;
        id_d        = id_q;
        we_d        = we_q;
        size_d      = size_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        mem_we_d    = 1'b0;
        mem_re_d    = 1'b0;
        mem_wdata_d = mem_wdata_q;
        fin         = 1'b0;
        fin_id      = id_q;
        fin_err     = 1'b0;
        fin_rdata   = '0;

        unique case (state_q)
            StIdle: begin
                if (gnt_valid) begin
                    id_d    = gnt_id;
                    we_d    = sel_we;
                    size_d  = sel_size;
                    addr_d  = sel_addr;
                    wdata_d = sel_wdata;
                    if (is_illegal(sel_size, sel_addr[1:0])) begin
                        state_d = StDone;
                        fin     = 1'b1;
                        fin_id  = gnt_id;
                        fin_err = 1'b1;
                    end else if (sel_we && (sel_size == SZ_WORD)) begin
                        state_d     = StWr;
                        mem_we_d    = 1'b1;
                        mem_wdata_d = sel_wdata;
                    end else begin
                        state_d  = StRd;
                        mem_re_d = 1'b1;
                    end
                end
            end
            StRd: state_d = StMerge;
            StMerge: begin
                if (we_q) begin
                    state_d     = StWr;
                    mem_we_d    = 1'b1;
                    mem_wdata_d = lane_merge(mem_rdata, wdata_q, size_q, addr_q[1:0]);
                end else begin
                    state_d   = StDone;
                    fin       = 1'b1;
                    fin_rdata = load_extract(mem_rdata, size_q, addr_q[1:0]);
                end
            end
            StWr: begin
                state_d = StDone;
                fin     = 1'b1;
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase

        // Result registers only move on their own port's completion.
        a_ack_d   = fin && !fin_id;
        b_ack_d   = fin && fin_id;
        a_err_d   = a_ack_d ? fin_err   : a_err_q;
        a_rdata_d = a_ack_d ? fin_rdata : a_rdata_q;
        b_err_d   = b_ack_d ? fin_err   : b_err_q;
        b_rdata_d = b_ack_d ? fin_rdata : b_rdata_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            id_q        <= 1'b0;
            we_q        <= 1'b0;
            size_q      <= 2'b00;
            addr_q      <= '0;
            wdata_q     <= '0;
            mem_we_q    <= 1'b0;
            mem_re_q    <= 1'b0;
            mem_wdata_q <= '0;
            a_ack_q     <= 1'b0;
            a_err_q     <= 1'b0;
            a_rdata_q   <= '0;
            b_ack_q     <= 1'b0;
            b_err_q     <= 1'b0;
            b_rdata_q   <= '0;
        end else begin
            state_q     <= state_d;
            id_q        <= id_d;
            we_q        <= we_d;
            size_q      <= size_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            mem_we_q    <= mem_we_d;
            mem_re_q    <= mem_re_d;
            mem_wdata_q <= mem_wdata_d;
            a_ack_q     <= a_ack_d;
            a_err_q     <= a_err_d;
            a_rdata_q   <= a_rdata_d;
            b_ack_q     <= b_ack_d;
            b_err_q     <= b_err_d;
            b_rdata_q   <= b_rdata_d;
        end
    end

    assign mem_addr     = addr_q[WORD_ADDR_W+1:2];
    assign mem_byte_sel = addr_q[1:0];
    assign mem_we       = mem_we_q;
    assign mem_re       = mem_re_q;
    assign mem_wdata    = mem_wdata_q;
    assign a_if.ack     = a_ack_q;
    assign a_if.err     = a_err_q;
    assign a_if.rdata   = a_rdata_q;
    assign b_if.ack     = b_ack_q;
    assign b_if.err     = b_err_q;
    assign b_if.rdata   = b_rdata_q;

endmodule

// File: tb/tb_mem_rmw_arbiter.sv
// Directed bench for mem_rmw_arbiter with a 1-cycle registered-read memory model.
module tb_mem_rmw_arbiter;
    import mem_pkg::*;

    localparam int unsigned WORD_ADDR_W = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mem_rmw_arbiter_if #(.WORD_ADDR_W(WORD_ADDR_W)) a_if ();
    mem_rmw_arbiter_if #(.WORD_ADDR_W(WORD_ADDR_W)) b_if ();

    logic [WORD_ADDR_W-1:0] mem_addr;
    logic [1:0]             mem_byte_sel;
    logic                   mem_we, mem_re;
    logic [31:0]            mem_wdata;
    logic [31:0]            mem_rdata = '0;

    mem_rmw_arbiter #(.WORD_ADDR_W(WORD_ADDR_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .a_if         (a_if),
        .b_if         (b_if),
        .mem_addr     (mem_addr),
        .mem_byte_sel (mem_byte_sel),
        .mem_we       (mem_we),
        .mem_re       (mem_re),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata)
    );

    logic [31:0] mem [0:1023];
    always @(posedge clk) begin
        if (mem_re) mem_rdata <= mem[mem_addr[9:0]];
        if (mem_we) mem[mem_addr[9:0]] <= mem_wdata;
    end

    int          act_cnt = 0, both_cnt = 0, wr_cnt = 0, a_ack_cnt = 0;
    logic [31:0] last_wr = '0;
    logic [1:0]  last_sel = '0;
    always @(posedge clk) begin
        if (mem_we || mem_re) act_cnt <= act_cnt + 1;
        if (mem_we && mem_re) both_cnt <= both_cnt + 1;
        if (mem_we) begin
            wr_cnt   <= wr_cnt + 1;
            last_wr  <= mem_wdata;
            last_sel <= mem_byte_sel;
        end
        if (a_if.ack) a_ack_cnt <= a_ack_cnt + 1;
    end

    int passed = 0;
    int total  = 0;

    task automatic drive(input bit port, input logic req, input logic we, input logic [1:0] size,
                         input logic [17:0] addr, input logic [31:0] wdata);
        if (!port) begin
            a_if.req = req; a_if.we = we; a_if.size = size; a_if.addr = addr; a_if.wdata = wdata;
        end else begin
            b_if.req = req; b_if.we = we; b_if.size = size; b_if.addr = addr; b_if.wdata = wdata;
        end
    endtask

    // Issue one request in an IDLE cycle and wait for its ack; lat counts edges from grant cycle.
    task automatic do_txn(input bit port, input logic we, input logic [1:0] size,
                          input logic [17:0] addr, input logic [31:0] wdata,
                          output int lat, output logic [31:0] rd, output logic er);
        @(negedge clk);
        drive(port, 1'b1, we, size, addr, wdata);
        lat = -1;
        rd  = 32'hXXXX_XXXX;
        er  = 1'bx;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (port ? b_if.ack : a_if.ack) begin
                lat = i;
                rd  = port ? b_if.rdata : a_if.rdata;
                er  = port ? b_if.err : a_if.err;
                break;
            end
        end
        drive(port, 1'b0, 1'b0, 2'b00, '0, '0);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 2'b00, '0, '0);
        drive(1'b1, 1'b0, 1'b0, 2'b00, '0, '0);
        repeat (3) @(negedge clk);
        total++;
        if ({a_if.ack, a_if.err, b_if.ack, b_if.err, mem_we, mem_re} !== 6'b0)
            $display("FAIL reset_ctrl: got %b want 000000",
                     {a_if.ack, a_if.err, b_if.ack, b_if.err, mem_we, mem_re});
        else passed++;
        total++;
        if ((a_if.rdata !== 32'h0) || (b_if.rdata !== 32'h0))
            $display("FAIL reset_rdata: got a=%h b=%h want 0", a_if.rdata, b_if.rdata);
        else passed++;
        total++;
        if ((mem_addr !== 16'h0) || (mem_wdata !== 32'h0) || (mem_byte_sel !== 2'b0))
            $display("FAIL reset_mem: got addr=%h wdata=%h sel=%b want 0",
                     mem_addr, mem_wdata, mem_byte_sel);
        else passed++;
        rst = 1'b0;
    endtask

    task automatic test_contention;
        logic [5:0] seq = '0;
        int n = 0, first_lat = -1, last_lat = -1, both_ack = 0;
        @(negedge clk);
        drive(1'b0, 1'b1, 1'b1, SZ_WORD, 18'h20, 32'hA0A0_A0A0);
        drive(1'b1, 1'b1, 1'b1, SZ_WORD, 18'h24, 32'hB0B0_B0B0);
        for (int i = 1; i <= 40 && n < 6; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (a_if.ack && b_if.ack) both_ack++;
            if (a_if.ack || b_if.ack) begin
                if (n == 0) first_lat = i;
                last_lat = i;
                seq[n] = b_if.ack;
                n++;
            end
        end
        drive(1'b0, 1'b0, 1'b0, 2'b00, '0, '0);
        drive(1'b1, 1'b0, 1'b0, 2'b00, '0, '0);
        total++;
        if (seq !== 6'b101010 || n !== 6)
            $display("FAIL contention_order: got seq=%b n=%0d want 101010 n=6", seq, n);
        else passed++;
        total++;
        if (first_lat !== 2) $display("FAIL contention_first_lat: got %0d want 2", first_lat);
        else passed++;
        total++;
        if (last_lat !== 17) $display("FAIL contention_last_lat: got %0d want 17", last_lat);
        else passed++;
        total++;
        if (both_ack !== 0) $display("FAIL contention_dual_ack: got %0d want 0", both_ack);
        else passed++;
        total++;
        if (mem[8] !== 32'hA0A0_A0A0 || mem[9] !== 32'hB0B0_B0B0)
            $display("FAIL contention_mem: got %h %h want a0a0a0a0 b0b0b0b0", mem[8], mem[9]);
        else passed++;
    endtask

    task automatic test_word_store_load;
        int lat; logic [31:0] rd; logic er;
        do_txn(1'b0, 1'b1, SZ_WORD, 18'h10, 32'hDEAD_BEEF, lat, rd, er);
        total++;
        if (lat !== 2 || er !== 1'b0 || rd !== 32'h0)
            $display("FAIL word_store: got lat=%0d err=%b rd=%h want 2 0 0", lat, er, rd);
        else passed++;
        total++;
        if (last_wr !== 32'hDEAD_BEEF || mem[4] !== 32'hDEAD_BEEF)
            $display("FAIL word_store_data: got wr=%h mem=%h want deadbeef", last_wr, mem[4]);
        else passed++;
        do_txn(1'b0, 1'b0, SZ_WORD, 18'h10, 32'h0, lat, rd, er);
        total++;
        if (lat !== 3 || er !== 1'b0 || rd !== 32'hDEAD_BEEF)
            $display("FAIL word_load: got lat=%0d err=%b rd=%h want 3 0 deadbeef", lat, er, rd);
        else passed++;
    endtask

    task automatic test_byte_rmw;
        int lat; logic [31:0] rd; logic er;
        do_txn(1'b0, 1'b1, SZ_BYTE, 18'h12, 32'hCCCC_CC55, lat, rd, er);
        total++;
        if (lat !== 4 || er !== 1'b0 || rd !== 32'h0)
            $display("FAIL byte_store: got lat=%0d err=%b rd=%h want 4 0 0", lat, er, rd);
        else passed++;
        total++;
        if (last_wr !== 32'hDE55_BEEF || last_sel !== 2'd2)
            $display("FAIL byte_merge: got wr=%h sel=%0d want de55beef 2", last_wr, last_sel);
        else passed++;
        do_txn(1'b0, 1'b0, SZ_HALF, 18'h12, 32'h0, lat, rd, er);
        total++;
        if (lat !== 3 || rd !== 32'h0000_DE55)
            $display("FAIL half_load: got lat=%0d rd=%h want 3 0000de55", lat, rd);
        else passed++;
        do_txn(1'b0, 1'b0, SZ_BYTE, 18'h13, 32'h0, lat, rd, er);
        total++;
        if (lat !== 3 || rd !== 32'h0000_00DE)
            $display("FAIL byte_load: got lat=%0d rd=%h want 3 000000de", lat, rd);
        else passed++;
        do_txn(1'b0, 1'b1, SZ_HALF, 18'h10, 32'hFFFF_1234, lat, rd, er);
        total++;
        if (lat !== 4 || rd !== 32'h0 || last_wr !== 32'hDE55_1234)
            $display("FAIL half_store: got lat=%0d rd=%h wr=%h want 4 0 de551234", lat, rd, last_wr);
        else passed++;
    endtask

    task automatic test_misaligned;
        int lat, act0; logic [31:0] rd; logic er;
        do_txn(1'b1, 1'b0, SZ_WORD, 18'h10, 32'h0, lat, rd, er);
        total++;
        if (rd !== 32'hDE55_1234) $display("FAIL b_word_load: got %h want de551234", rd);
        else passed++;
        act0 = act_cnt;
        do_txn(1'b1, 1'b1, SZ_HALF, 18'h05, 32'h0000_FFFF, lat, rd, er);
        total++;
        if (lat !== 1 || er !== 1'b1 || rd !== 32'h0)
            $display("FAIL mis_half_store: got lat=%0d err=%b rd=%h want 1 1 0", lat, er, rd);
        else passed++;
        do_txn(1'b1, 1'b0, SZ_WORD, 18'h06, 32'h0, lat, rd, er);
        total++;
        if (lat !== 1 || er !== 1'b1 || rd !== 32'h0)
            $display("FAIL mis_word_load: got lat=%0d err=%b rd=%h want 1 1 0", lat, er, rd);
        else passed++;
        repeat (3) @(negedge clk);
        total++;
        if (act_cnt !== act0) $display("FAIL mis_mem_access: got %0d want %0d", act_cnt, act0);
        else passed++;
        total++;
        if (b_if.err !== 1'b1 || b_if.ack !== 1'b0)
            $display("FAIL err_hold: got err=%b ack=%b want 1 0", b_if.err, b_if.ack);
        else passed++;
    endtask

    task automatic test_reserved_size;
        int a_lat = -1, b_lat = -1;
        logic a_er = 1'bx, b_er = 1'bx;
        logic [31:0] a_rd = 'x, b_rd = 'x;
        @(negedge clk);
        drive(1'b0, 1'b1, 1'b0, SZ_RSVD, 18'h10, 32'h0);
        drive(1'b1, 1'b1, 1'b0, SZ_WORD, 18'h10, 32'h0);
        for (int i = 1; i <= 30 && b_lat < 0; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (a_if.ack) begin
                a_lat = i; a_er = a_if.err; a_rd = a_if.rdata;
                drive(1'b0, 1'b0, 1'b0, 2'b00, '0, '0);
            end
            if (b_if.ack) begin
                b_lat = i; b_er = b_if.err; b_rd = b_if.rdata;
                drive(1'b1, 1'b0, 1'b0, 2'b00, '0, '0);
            end
        end
        drive(1'b0, 1'b0, 1'b0, 2'b00, '0, '0);
        drive(1'b1, 1'b0, 1'b0, 2'b00, '0, '0);
        total++;
        if (a_lat !== 1 || a_er !== 1'b1 || a_rd !== 32'h0)
            $display("FAIL rsvd_size: got lat=%0d err=%b rd=%h want 1 1 0", a_lat, a_er, a_rd);
        else passed++;
        total++;
        if (b_lat !== 5 || b_er !== 1'b0 || b_rd !== 32'hDE55_1234)
            $display("FAIL rsvd_b_next: got lat=%0d err=%b rd=%h want 5 0 de551234",
                     b_lat, b_er, b_rd);
        else passed++;
    endtask

    task automatic test_reset_mid_rmw;
        int lat, wr0, ack0; logic [31:0] rd; logic er;
        wr0  = wr_cnt;
        ack0 = a_ack_cnt;
        @(negedge clk);
        drive(1'b0, 1'b1, 1'b1, SZ_BYTE, 18'h10, 32'h0000_0077);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 2'b00, '0, '0);
        #1;
        total++;
        if (mem_we !== 1'b0 || mem_re !== 1'b0)
            $display("FAIL rst_strobes: got we=%b re=%b want 0 0", mem_we, mem_re);
        else passed++;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        total++;
        if (wr_cnt !== wr0 || a_ack_cnt !== ack0)
            $display("FAIL rst_abandon: got wr=%0d ack=%0d want %0d %0d",
                     wr_cnt, a_ack_cnt, wr0, ack0);
        else passed++;
        do_txn(1'b0, 1'b0, SZ_WORD, 18'h10, 32'h0, lat, rd, er);
        total++;
        if (lat !== 3 || rd !== 32'hDE55_1234)
            $display("FAIL rst_readback: got lat=%0d rd=%h want 3 de551234", lat, rd);
        else passed++;
    endtask

    task automatic test_strobe_exclusive;
        total++;
        if (both_cnt !== 0) $display("FAIL strobe_excl: got %0d want 0", both_cnt);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_contention();
        test_word_store_load();
        test_byte_rmw();
        test_misaligned();
        test_reserved_size();
        test_reset_mid_rmw();
        test_strobe_exclusive();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mem_rmw_arbiter.md
Name: mem_rmw_arbiter

Overview:
- Front-end controller for the 32-bit little-endian byte-addressable memory (16-bit word address, word writes only, 1-cycle registered reads).
- Shares the memory between two requesters (A, B) with round-robin arbitration.
- Adds byte and halfword stores by sequencing read-modify-write; returns zero-extended byte/halfword/word loads.
- Sits between CPU-side masters and the memory instance.

Parameters:
WORD_ADDR_W, 16, memory word-address width; byte address width is WORD_ADDR_W+2

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous, active-high reset
a_req  in  1  requester A request; held high with stable fields until a_ack
a_we  in  1  1 = store, 0 = load
a_size  in  2  00 byte, 01 halfword, 10 word, 11 reserved
a_addr  in  WORD_ADDR_W+2  byte address
a_wdata  in  32  store data, right-justified (byte in [7:0], half in [15:0])
a_ack  out  1  one-cycle completion pulse
a_err  out  1  valid with a_ack: misaligned or reserved size
a_rdata  out  32  load result, zero-extended; valid with a_ack
b_req, b_we, b_size, b_addr, b_wdata, b_ack, b_err, b_rdata  same as A, for requester B
mem_addr  out  WORD_ADDR_W  word address
mem_byte_sel  out  2  byte lane, equals latched addr[1:0]
mem_we  out  1  memory write strobe
mem_re  out  1  memory read strobe
mem_wdata  out  32  word written to memory
mem_rdata  in  32  memory read_data; valid the cycle after mem_re

Behaviour:
- Reset (async, rst=1):
  - State = IDLE; all acks/errs/rdata = 0; mem_we = mem_re = 0; mem_addr/mem_wdata/mem_byte_sel = 0.
  - Round-robin pointer favours A.
  - An in-flight transaction is abandoned with no ack. A requester still holding req is re-arbitrated after reset release.
- States: IDLE, RD, MERGE, WR, DONE.
- IDLE arbitration:
  - If one req is high, grant that requester.
  - If both are high, grant the requester not granted last; the pointer flips after each grant.
  - Latch we/size/addr/wdata and the granted id at the edge.
- Next state from IDLE:
  - Illegal request goes to DONE with err=1, and no memory access occurs. Illegal means size=11, size=01 with addr[0]=1, or size=10 with addr[1:0]!=0.
  - Aligned word store goes to WR.
  - All other requests go to RD.
- RD: mem_re=1, mem_we=0, mem_addr=addr[WORD_ADDR_W+1:2]; next state MERGE.
- MERGE: capture mem_rdata.
  - Load: rdata = (mem_rdata >> 8*addr[1:0]) masked to size; next state DONE.
  - Partial store: build merged word by replacing lane(s) addr[1:0] (byte) or addr[1]*2..+1 (half) with the low bits of wdata; next state WR.
- WR: mem_we=1, mem_re=0, mem_wdata = full wdata (word store) or merged word; next state DONE.
- DONE:
  - Granted requester's ack=1 for exactly this cycle, with err and rdata valid. Store rdata = 0.
  - Next state IDLE.
- rdata and err hold their value after ack until the next ack of that port.
- Latency (T0 = IDLE cycle in which the request is granted; ack cycle):
  - illegal: T1
  - word store: T2
  - load: T3
  - partial store: T4
- mem_we and mem_re are never high in the same cycle. Both are 0 in IDLE, MERGE and DONE.
- Requester rule: req may drop or change in the cycle after ack. A req still high in IDLE is treated as a new request.
- Non-granted requester waits with ack=0; at most one transaction is in flight at a time.
- Requests arriving in any non-IDLE state are ignored until IDLE.

Decomposition:
- Shared package mem_pkg:
  - size encodings SZ_BYTE/SZ_HALF/SZ_WORD
  - state enum for IDLE..DONE
  - function lane_merge(old, wdata, size, off) and function load_extract(word, size, off)
- One natural sub-module: rr_arb2, a 2-input round-robin arbiter with pointer register, taking clk and rst.

Test Plan:
- Word store then load: A stores 0xDEADBEEF at 0x0010 (ack at T2), then loads word 0x0010 → a_rdata = 0xDEADBEEF, err = 0, ack at T3.
- Byte RMW: after the above, A stores byte 0x55 at 0x0012 → mem_wdata in WR = 0xDE55BEEF. Halfword load at 0x0012 → 0x0000DE55. Byte load at 0x0013 → 0x000000DE.
- Contention: A and B both req in the same IDLE cycle after reset → A granted first, then B. With both held continuously, grants alternate A, B, A, B, and no ack is lost.
- Misaligned: B halfword store at 0x0005, then word load at 0x0006 → each acks at T1 with b_err = 1, b_rdata = 0, and mem_we/mem_re never asserted.
- Reset mid-RMW: assert rst during MERGE of a byte store → mem_we stays 0, no ack, memory word unchanged (read back the original value after reset).
- Reserved size 11 on A load → a_ack with a_err = 1 at T1, and B's pending request is served next.
